mux_2to1: RTL and testbench

//   Parameterised 2:1 selector: drives y from i0 when sel=0 and from i1 when sel=1.

---
 rtl/mux_2to1_pkg.sv | 8 +
 rtl/mux_2to1.sv | 46 ++++
 tb/tb_mux_2to1.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/mux_2to1_pkg.sv
// Shared defaults for the 2:1 selector leaf primitive.
// No state, no latency, no backpressure: constants only.
package mux_2to1_pkg;

    localparam int MUX_WIDTH_DEF = 1;
    localparam int MUX_CNT_W_DEF = 8;

endpackage

// File: rtl/mux_2to1.sv
// 2:1 selector with a registered copy of y and a saturating count of sel=1 cycles.
// Latency: y combinational, y_q one cycle; no backpressure (always accepts).
module mux_2to1
    import mux_2to1_pkg::*;
#(
    parameter int WIDTH = MUX_WIDTH_DEF,
    parameter int CNT_W = MUX_CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i0,
    input  logic [WIDTH-1:0] i1,
    input  logic             sel,
    output logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] y_q,
    output logic [CNT_W-1:0] sel1_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Plain ?: so an unknown select merges agreeing bits and leaves the rest X.
    assign y = sel ? i1 : i0;

    always_comb begin
        cnt_d = cnt_q;
        if (sel && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            y_q   <= '0;
            cnt_q <= '0;
        end else begin
            y_q   <= y;
            cnt_q <= cnt_d;
        end
    end

    assign sel1_cnt = cnt_q;

endmodule

// File: tb/tb_mux_2to1.sv
// Directed bench for mux_2to1 across four parameterisations sharing one clock and reset.
module tb_mux_2to1;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    // A: WIDTH=1, CNT_W=8
    logic       a_i0, a_i1, a_sel, a_y, a_yq;
    logic [7:0] a_cnt;
    // B: WIDTH=1, CNT_W=2
    logic       b_i0, b_i1, b_sel, b_y, b_yq;
    logic [1:0] b_cnt;
    // C: WIDTH=4
    logic [3:0] c_i0, c_i1, c_y, c_yq;
    logic       c_sel;
    logic [7:0] c_cnt;
    // D: WIDTH=16
    logic [15:0] d_i0, d_i1, d_y, d_yq;
    logic        d_sel;
    logic [7:0]  d_cnt;

    mux_2to1 #(.WIDTH(1), .CNT_W(8)) u_a (
        .clk(clk), .rst(rst), .i0(a_i0), .i1(a_i1), .sel(a_sel),
        .y(a_y), .y_q(a_yq), .sel1_cnt(a_cnt)
    );
    mux_2to1 #(.WIDTH(1), .CNT_W(2)) u_b (
        .clk(clk), .rst(rst), .i0(b_i0), .i1(b_i1), .sel(b_sel),
        .y(b_y), .y_q(b_yq), .sel1_cnt(b_cnt)
    );
    mux_2to1 #(.WIDTH(4), .CNT_W(8)) u_c (
        .clk(clk), .rst(rst), .i0(c_i0), .i1(c_i1), .sel(c_sel),
        .y(c_y), .y_q(c_yq), .sel1_cnt(c_cnt)
    );
    mux_2to1 #(.WIDTH(16), .CNT_W(8)) u_d (
        .clk(clk), .rst(rst), .i0(d_i0), .i1(d_i1), .sel(d_sel),
        .y(d_y), .y_q(d_yq), .sel1_cnt(d_cnt)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0]  exp_tbl;
        logic [2:0]  vec;
        logic [1:0]  sat_tbl [5];
        logic        r0, r1, rs;
        logic [15:0] d_exp, d_prev;

        rst   = 1'b1;
        a_i0  = 1'b0; a_i1 = 1'b0; a_sel = 1'b0;
        b_i0  = 1'b0; b_i1 = 1'b0; b_sel = 1'b0;
        c_i0  = '0;   c_i1 = '0;   c_sel = 1'b0;
        d_i0  = '0;   d_i1 = '0;   d_sel = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_yq", 32'(a_yq), 32'd0);
        check("rst_cnt", 32'(a_cnt), 32'd0);

        // Exhaustive WIDTH=1; index = {i0,i1,sel}, expected y per index hand-derived.
        exp_tbl = 8'b1101_1000;
        for (int v = 0; v < 8; v++) begin
            vec   = 3'(v);
            a_i0  = vec[2];
            a_i1  = vec[1];
            a_sel = vec[0];
            #2;
            check($sformatf("exh_%0d", v), 32'(a_y), 32'(exp_tbl[v]));
        end

        for (int k = 0; k < 10; k++) begin
            r0 = 1'($urandom_range(1, 0));
            r1 = 1'($urandom_range(1, 0));
            rs = 1'($urandom_range(1, 0));
            a_i0 = r0; a_i1 = r1; a_sel = rs;
            #2;
            check($sformatf("rnd_%0d", k), 32'(a_y), 32'(rs ? r1 : r0));
        end

        // Reset held two edges, y still live.
        @(negedge clk);
        a_i0 = 1'b1; a_i1 = 1'b0; a_sel = 1'b0;
        rst  = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk);
            #2;
            check($sformatf("rsthold_yq_%0d", k), 32'(a_yq), 32'd0);
            check($sformatf("rsthold_cnt_%0d", k), 32'(a_cnt), 32'd0);
            check($sformatf("rsthold_y_%0d", k), 32'(a_y), 32'd1);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #2;
        check("rel_yq", 32'(a_yq), 32'd1);
        check("rel_cnt", 32'(a_cnt), 32'd0);

        // Count three sel=1 edges, then reset mid-operation.
        @(negedge clk);
        a_sel = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        check("cnt3", 32'(a_cnt), 32'd3);
        check("cnt3_yq", 32'(a_yq), 32'd0);
        @(negedge clk);
        a_sel = 1'b0;
        @(posedge clk);
        #2;
        check("cnt_hold_sel0", 32'(a_cnt), 32'd3);
        check("yq_follow", 32'(a_yq), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #2;
        check("midrst_cnt", 32'(a_cnt), 32'd0);
        check("midrst_yq", 32'(a_yq), 32'd0);
        check("midrst_y", 32'(a_y), 32'd1);

        // Saturation at CNT_W=2.
        sat_tbl[0] = 2'd1; sat_tbl[1] = 2'd2; sat_tbl[2] = 2'd3;
        sat_tbl[3] = 2'd3; sat_tbl[4] = 2'd3;
        @(negedge clk);
        rst   = 1'b0;
        b_sel = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #2;
            check($sformatf("sat_%0d", k), 32'(b_cnt), 32'(sat_tbl[k]));
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #2;
        check("sat_rst", 32'(b_cnt), 32'd0);
        @(negedge clk);
        rst   = 1'b0;
        b_sel = 1'b0;

        // Unknown select: bits where inputs agree must still resolve.
        c_i0  = 4'b1010;
        c_i1  = 4'b1001;
        c_sel = 1'bx;
        #2;
        check("xsel_agree", 32'(c_y[3:2]), 32'b10);
        c_sel = 1'b1;
        #2;
        check("c_sel1", 32'(c_y), 32'b1001);
        c_sel = 1'b0;
        #2;
        check("c_sel0", 32'(c_y), 32'b1010);

        // Wide data toggling every cycle.
        @(negedge clk);
        d_i0  = 16'hA5A5;
        d_i1  = 16'h5A5A;
        d_sel = 1'b0;
        @(posedge clk);
        d_prev = 16'hA5A5;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            d_sel = (k % 2 == 0) ? 1'b1 : 1'b0;
            d_exp = (k % 2 == 0) ? 16'h5A5A : 16'hA5A5;
            #2;
            check($sformatf("wide_y_%0d", k), 32'(d_y), 32'(d_exp));
            check($sformatf("wide_yq_%0d", k), 32'(d_yq), 32'(d_prev));
            @(posedge clk);
            d_prev = d_exp;
        end
        #2;
        check("wide_yq_last", 32'(d_yq), 32'(d_prev));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
